// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Digit-counter width: enough bits to count N digits, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor stage: d = a - b - bin with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor computing a - b - bin, DIGIT bits per cycle.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = cnt_width(N);

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH");
  end

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [WIDTH-1:0]     diff_q, diff_d;
  logic                 brw_q, brw_d;
  logic                 borrow_q, borrow_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DIGIT:0]       chain;
  logic [DIGIT-1:0]     dig;
  logic [WIDTH+DIGIT-1:0] res_cat;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic                 a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic                 ovf_q, ovf_d;
`endif

  // Per-cycle borrow chain across the low DIGIT bits of the operand registers.
  assign chain[0] = brw_q;
  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fs
    full_subtractor u_fs (
      .a    (a_q[gi]),
      .b    (b_q[gi]),
      .bin  (chain[gi]),
      .d    (dig[gi]),
      .bout (chain[gi+1])
    );
  end

  // New digit enters the result register from the MSB side.
  assign res_cat = {dig, res_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    brw_d    = brw_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        res_d = res_cat[WIDTH+DIGIT-1:DIGIT];
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        brw_d = chain[DIGIT];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d  = ST_DONE;
          diff_d   = res_d;
          borrow_d = chain[DIGIT];
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d    = (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      brw_q    <= 1'b0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      brw_q    <= brw_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: two 8-bit instances (DIGIT=1 and DIGIT=4) against a cycle-level model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       bin = 1'b0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;

  logic       busy0, done0, borrow0, busy1, done1, borrow1;
  logic [7:0] diff0, diff1;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       ovf0, ovf1;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy0), .done(done0), .diff(diff0), .borrow(borrow0)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf0)
`endif
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf1)
`endif
  );

  // Model: remaining run cycles plus the result the pending operation will publish.
  int         m_rem [2];
  logic       m_busy [2], m_done [2], m_borrow [2], p_borrow [2];
  logic [7:0] m_diff [2], p_diff [2];
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       m_ovf [2], p_ovf [2];
`endif

  function automatic int ncyc(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
      m_diff[i] = 8'd0; m_borrow[i] = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      m_ovf[i] = 1'b0;
`endif
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (m_rem[i] > 0) begin
        m_rem[i]--;
        m_done[i] = 1'b0;
        if (m_rem[i] == 0) begin
          m_busy[i]   = 1'b0;
          m_done[i]   = 1'b1;
          m_diff[i]   = p_diff[i];
          m_borrow[i] = p_borrow[i];
`ifdef SERIAL_SUB_OVERFLOW_EN
          m_ovf[i]    = p_ovf[i];
`endif
        end
      end else begin
        m_done[i] = 1'b0;
        m_busy[i] = 1'b0;
        if (start) begin
          p_diff[i]   = 8'(int'(a) - int'(b) - int'(bin));
          p_borrow[i] = (int'(a) < int'(b) + int'(bin));
`ifdef SERIAL_SUB_OVERFLOW_EN
          p_ovf[i]    = (a[7] != b[7]) && (p_diff[i][7] != a[7]);
`endif
          m_rem[i]    = ncyc(i);
          m_busy[i]   = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("busy0",   32'(busy0),   32'(m_busy[0]));
    chk("done0",   32'(done0),   32'(m_done[0]));
    chk("diff0",   32'(diff0),   32'(m_diff[0]));
    chk("borrow0", 32'(borrow0), 32'(m_borrow[0]));
    chk("busy1",   32'(busy1),   32'(m_busy[1]));
    chk("done1",   32'(done1),   32'(m_done[1]));
    chk("diff1",   32'(diff1),   32'(m_diff[1]));
    chk("borrow1", 32'(borrow1), 32'(m_borrow[1]));
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf0",    32'(ovf0),    32'(m_ovf[0]));
    chk("ovf1",    32'(ovf1),    32'(m_ovf[1]));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  // Scramble operands after acceptance: they need only be valid in the start cycle.
  task automatic scramble();
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
  endtask

  task automatic wait_done0(inout int cyc);
    while (done0 !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int cyc;
    a = ia; b = ib; bin = ibin; start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    cyc = 1;
    wait_done0(cyc);
    chk("latency", 32'(cyc), 32'd9);
    chk("lit_diff", 32'(diff0), 32'(ed));
    chk("lit_borrow", 32'(borrow0), 32'(eb));
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("lit_ovf", 32'(ovf0), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected x flag");
`endif
  endtask

  initial begin
    int cyc;
    model_reset();
    #2;
    compare_all();
    #10 rst_n = 1'b1;
    tick(); tick();

    run_op(8'd200, 8'd55, 1'b0, 8'd145, 1'b0, 1'b0);
    run_op(8'd5,   8'd10, 1'b0, 8'd251, 1'b1, 1'b0);
    run_op(8'd0,   8'd0,  1'b1, 8'd255, 1'b1, 1'b0);
    repeat (10) tick();

    // Start while busy is ignored.
    a = 8'd9; b = 8'd3; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; scramble();
    tick(); tick();
    a = 8'd1; b = 8'd1; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; scramble();
    cyc = 4;
    wait_done0(cyc);
    chk("ign_latency", 32'(cyc), 32'd9);
    chk("ign_diff", 32'(diff0), 32'd6);
    repeat (10) tick();

    // Start held through DONE gives back-to-back operations.
    a = 8'd20; b = 8'd7; bin = 1'b0; start = 1'b1;
    tick();
    a = 8'd50; b = 8'd8;
    cyc = 1;
    wait_done0(cyc);
    chk("b2b_lat1", 32'(cyc), 32'd9);
    chk("b2b_diff1", 32'(diff0), 32'd13);
    tick();
    start = 1'b0; scramble();
    cyc = 1;
    wait_done0(cyc);
    chk("b2b_lat2", 32'(cyc), 32'd9);
    chk("b2b_diff2", 32'(diff0), 32'd42);
    repeat (10) tick();

    // Reset in RUN cycle 4 aborts the operation.
    a = 8'd77; b = 8'd3; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_diff", 32'(diff0), 32'd0);
    repeat (12) tick();
    rst_n = 1'b1;
    run_op(8'd100, 8'd1, 1'b0, 8'd99, 1'b0, 1'b0);
    repeat (10) tick();

    // DIGIT=4 instance: two-cycle run.
    a = 8'h3C; b = 8'h0F; bin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; scramble();
    cyc = 1;
    while (done1 !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("d4_latency", 32'(cyc), 32'd3);
    chk("d4_diff", 32'(diff1), 32'h2C);
    chk("d4_borrow", 32'(borrow1), 32'd0);
    repeat (10) tick();

`ifdef SERIAL_SUB_OVERFLOW_EN
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    repeat (10) tick();
`endif

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      start = ($urandom_range(0, 3) != 0);
      scramble();
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
